// File: rtl/ifetch_unit.sv
// ifetch_unit: holds the PC, issues in-order word fetches, buffers responses in a prefetch
// FIFO and feeds decode. Define IFETCH_PERF_CNT_EN to add perf_fetched / perf_stall counters.
`ifndef BITWIDTH
`define BITWIDTH 32
`endif

module ifetch_unit #(
  parameter logic [`BITWIDTH-1:0] RESET_PC   = '0,
  parameter int                   FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 imem_req_valid,
  input  logic                 imem_req_ready,
  output logic [`BITWIDTH-1:0] imem_req_addr,
  input  logic                 imem_rsp_valid,
  input  logic [31:0]          imem_rsp_data,
  input  logic                 redirect_valid,
  input  logic [`BITWIDTH-1:0] redirect_pc,
  output logic                 id_valid,
  input  logic                 id_ready,
  output logic [31:0]          id_instr,
  output logic [6:0]           id_opcode,
  output logic [`BITWIDTH-1:0] id_pc
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0]          perf_fetched,
  output logic [31:0]          perf_stall
`endif
);

  // Handshakes (imem request, decode output): a transfer happens on a rising edge where
  // valid && ready; valid never depends on ready, and ready may change at any time.
  localparam int          PW  = `BITWIDTH;
  localparam int          AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int          CW  = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [PW-1:0] fetch_pc_q, fetch_pc_d;
  logic [PW-1:0] rsp_pc_q, rsp_pc_d;
  logic [31:0]   data_mem_q [FIFO_DEPTH];
  logic [31:0]   data_mem_d [FIFO_DEPTH];
  logic [PW-1:0] pc_mem_q [FIFO_DEPTH];
  logic [PW-1:0] pc_mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] discard_q, discard_d;

  logic [PW-1:0] redirect_base;
  logic [CW:0]   in_use;
  logic          fifo_empty;
  logic          req_fire;
  logic          rsp_ok;
  logic          push;
  logic          pop;

  assign redirect_base  = redirect_pc & ~PW'(3);
  // Credits cover both in-flight words and buffered words, so a push never finds the FIFO full.
  assign in_use         = {1'b0, outstanding_q} + {1'b0, fifo_cnt_q};
  assign fifo_empty     = (fifo_cnt_q == '0);
  assign imem_req_valid = !rst && !redirect_valid && (in_use < (CW+1)'(FIFO_DEPTH));
  assign imem_req_addr  = fetch_pc_q;

  assign id_valid  = !rst && !fifo_empty && !redirect_valid;
  assign id_instr  = fifo_empty ? NOP : data_mem_q[rd_ptr_q];
  assign id_opcode = id_instr[6:0];
  assign id_pc     = fifo_empty ? rsp_pc_q : pc_mem_q[rd_ptr_q];

  assign req_fire = imem_req_valid && imem_req_ready;
  // A response with nothing outstanding is a protocol error and is ignored outright.
  assign rsp_ok   = imem_rsp_valid && (outstanding_q != '0);
  assign pop      = id_valid && id_ready;
  assign push     = rsp_ok && !redirect_valid && (discard_q == '0);

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    fifo_cnt_d    = fifo_cnt_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    data_mem_d    = data_mem_q;
    pc_mem_d      = pc_mem_q;
    if (redirect_valid) begin
      // Everything still in flight, minus the word dropped this cycle, belongs to the old path.
      fetch_pc_d    = redirect_base;
      rsp_pc_d      = redirect_base;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      fifo_cnt_d    = '0;
      outstanding_d = outstanding_q - CW'(rsp_ok);
      discard_d     = outstanding_q - CW'(rsp_ok);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + PW'(4);
      outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_ok);
      if (rsp_ok && (discard_q != '0)) discard_d = discard_q - CW'(1);
      if (push) begin
        data_mem_d[wr_ptr_q] = imem_rsp_data;
        pc_mem_d[wr_ptr_q]   = rsp_pc_q;
        wr_ptr_d             = wr_ptr_q + AW'(1);
        rsp_pc_d             = rsp_pc_q + PW'(4);
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fifo_cnt_q    <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fifo_cnt_q    <= fifo_cnt_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  // Storage needs no reset: entries are only read while fifo_cnt_q says they are valid.
  always_ff @(posedge clk) begin
    data_mem_q <= data_mem_d;
    pc_mem_q   <= pc_mem_d;
  end

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q + 32'(pop);
    perf_stall_d   = perf_stall_q + 32'(id_valid && !id_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Testbench for ifetch_unit: in-order memory model with random latency plus a queue-based
// reference of the fetch stage; each scenario task checks every cycle and its own endpoints.
module tb_ifetch_unit;

  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam int          VW    = 169;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid, id_ready;
  logic [31:0] id_instr;
  logic [6:0]  id_opcode;
  logic [31:0] id_pc;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_stall;
`endif

  always #5 clk = ~clk;

  ifetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_instr(id_instr), .id_opcode(id_opcode), .id_pc(id_pc)
`ifdef IFETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
  );

  // Memory model: fixed-order responses, each due no earlier than its latency allows.
  typedef struct { logic [31:0] data; int due; } mrsp_t;
  mrsp_t mem_q[$];
  int    last_due;
  int    lat_min, lat_max;
  bit    stray_rsp;

  // Reference model: exp_q holds buffered {pc, instr} words in delivery order.
  logic [63:0] exp_q[$];
  logic [31:0] m_fetch_pc, m_rsp_pc;
  int          m_out, m_discard;
  logic [31:0] m_fetched, m_stall;

  int cyc, n_vec, n_err;
  logic              exp_req_valid, exp_id_valid;
  logic [31:0]       exp_instr, exp_pc;
  logic [VW-1:0]     obs_vec, exp_vec;
  logic [63:0]       obs_perf, exp_perf;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Drive this cycle's response, move to the falling edge and build observed/expected vectors.
  task automatic settle();
    if (stray_rsp) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = $urandom;
    end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_q[0].data;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    @(negedge clk);
    exp_req_valid = !rst && !redirect_valid && ((m_out + exp_q.size()) < DEPTH);
    exp_id_valid  = !rst && (exp_q.size() > 0) && !redirect_valid;
    exp_instr     = (exp_q.size() > 0) ? exp_q[0][31:0] : NOP;
    exp_pc        = (exp_q.size() > 0) ? exp_q[0][63:32] : m_rsp_pc;
`ifdef IFETCH_PERF_CNT_EN
    obs_perf = {perf_fetched, perf_stall};
    exp_perf = {m_fetched, m_stall};
`else
    obs_perf = 64'h0;
    exp_perf = 64'h0;
`endif
    if (rst) begin
      obs_vec = {imem_req_valid, 32'h0, id_valid, 135'h0};
      exp_vec = {1'b0, 32'h0, 1'b0, 135'h0};
    end else begin
      obs_vec = {imem_req_valid, imem_req_addr, id_valid, id_instr, id_opcode, id_pc, obs_perf};
      exp_vec = {exp_req_valid, m_fetch_pc, exp_id_valid, exp_instr, exp_instr[6:0], exp_pc,
                 exp_perf};
    end
  endtask

  // Apply this cycle's events to the memory and reference models, then cross the rising edge.
  task automatic advance();
    logic dut_fire, m_fire, rsp, rsp_ok;
    int   lat, due;
    dut_fire = imem_req_valid && imem_req_ready;
    m_fire   = exp_req_valid && imem_req_ready;
    rsp      = imem_rsp_valid;
    rsp_ok   = rsp && (m_out > 0);
    if (rst) begin
      mem_q.delete();
      exp_q.delete();
      last_due   = 0;
      m_fetch_pc = 32'h0;
      m_rsp_pc   = 32'h0;
      m_out      = 0;
      m_discard  = 0;
      m_fetched  = 32'h0;
      m_stall    = 32'h0;
    end else begin
      if (rsp && !stray_rsp && mem_q.size() > 0) void'(mem_q.pop_front());
      if (dut_fire) begin
        lat = $urandom_range(lat_min, lat_max);
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        mem_q.push_back('{mem_word(imem_req_addr), due});
      end
      if (exp_id_valid) begin
        if (id_ready) m_fetched = m_fetched + 1;
        else          m_stall   = m_stall + 1;
      end
      if (redirect_valid) begin
        m_fetch_pc = redirect_pc & ~32'h3;
        m_rsp_pc   = redirect_pc & ~32'h3;
        exp_q.delete();
        m_discard  = m_out - (rsp_ok ? 1 : 0);
        m_out      = m_discard;
      end else begin
        if (exp_id_valid && id_ready) void'(exp_q.pop_front());
        if (m_fire) begin
          m_fetch_pc = m_fetch_pc + 32'd4;
          m_out      = m_out + 1;
        end
        if (rsp_ok) begin
          m_out = m_out - 1;
          if (m_discard > 0) m_discard = m_discard - 1;
          else begin
            exp_q.push_back({m_rsp_pc, imem_rsp_data});
            m_rsp_pc = m_rsp_pc + 32'd4;
          end
        end
      end
    end
    stray_rsp = 1'b0;
    @(posedge clk);
    #1;
    cyc = cyc + 1;
  endtask

  task automatic do_reset(input int n);
    rst            = 1'b1;
    redirect_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      settle();
      advance();
    end
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] addrs[$];
    logic [31:0] pcs[$];
    logic [31:0] got;
    lat_min = 1; lat_max = 1;
    imem_req_ready = 1'b1; id_ready = 1'b1; redirect_valid = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 15; i++) begin
      if (i == 3) rst = 1'b0;
      settle();
      n_vec++;
      if (obs_vec !== exp_vec) begin
        n_err++;
        $display("FAIL reset_seq cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
      end
      if (!rst && imem_req_valid && imem_req_ready) addrs.push_back(imem_req_addr);
      if (!rst && id_valid && id_ready) pcs.push_back(id_pc);
      advance();
    end
    for (int k = 0; k < 3; k++) begin
      got = (addrs.size() > k) ? addrs[k] : 32'hDEAD_BEEF;
      n_vec++;
      if (got !== 32'(4 * k)) begin
        n_err++;
        $display("FAIL reset_req_addr[%0d] got=%h exp=%h", k, got, 32'(4 * k));
      end
      got = (pcs.size() > k) ? pcs[k] : 32'hDEAD_BEEF;
      n_vec++;
      if (got !== 32'(4 * k)) begin
        n_err++;
        $display("FAIL reset_id_pc[%0d] got=%h exp=%h", k, got, 32'(4 * k));
      end
    end
  endtask

  task automatic test_decode_stall();
    int          nreq;
    int          npop;
    logic        last_rv;
    logic [31:0] next_pc;
    lat_min = 1; lat_max = 1; imem_req_ready = 1'b1;
    do_reset(2);
    id_ready = 1'b0;
    nreq = 0;
    last_rv = 1'b1;
    for (int i = 0; i < 10; i++) begin
      settle();
      n_vec++;
      if (obs_vec !== exp_vec) begin
        n_err++;
        $display("FAIL stall_hold cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
      end
      if (imem_req_valid && imem_req_ready) nreq++;
      last_rv = imem_req_valid;
      advance();
    end
    n_vec++;
    if (nreq != DEPTH) begin
      n_err++;
      $display("FAIL stall_req_count got=%0d exp=%0d", nreq, DEPTH);
    end
    n_vec++;
    if (last_rv !== 1'b0) begin
      n_err++;
      $display("FAIL stall_req_valid got=%b exp=0", last_rv);
    end
    id_ready = 1'b1;
    next_pc = 32'h0;
    npop = 0;
    for (int i = 0; i < 16; i++) begin
      settle();
      n_vec++;
      if (obs_vec !== exp_vec) begin
        n_err++;
        $display("FAIL stall_resume cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
      end
      if (id_valid && id_ready) begin
        n_vec++;
        if (id_pc !== next_pc) begin
          n_err++;
          $display("FAIL stall_order got=%h exp=%h", id_pc, next_pc);
        end
        next_pc = next_pc + 32'd4;
        npop++;
      end
      advance();
    end
    n_vec++;
    if (npop < 6) begin
      n_err++;
      $display("FAIL stall_resume_count got=%0d exp>=6", npop);
    end
  endtask

  task automatic test_redirect_inflight();
    bit          found, seen;
    logic [31:0] got_pc, got_instr;
    lat_min = 3; lat_max = 3; imem_req_ready = 1'b1; id_ready = 1'b1;
    do_reset(2);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_out == 2) found = 1;
      else begin
        settle();
        n_vec++;
        if (obs_vec !== exp_vec) begin
          n_err++;
          $display("FAIL inflight_pre cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
        end
        advance();
      end
    end
    n_vec++;
    if (!found) begin
      n_err++;
      $display("FAIL inflight_timeout got=%0d outstanding exp=2", m_out);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    seen = 0;
    got_pc = 32'hDEAD_BEEF;
    got_instr = 32'hDEAD_BEEF;
    for (int i = 0; i < 20; i++) begin
      settle();
      n_vec++;
      if (obs_vec !== exp_vec) begin
        n_err++;
        $display("FAIL inflight_post cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
      end
      if (!seen && id_valid && id_ready) begin
        seen = 1;
        got_pc = id_pc;
        got_instr = id_instr;
      end
      advance();
      redirect_valid = 1'b0;
    end
    n_vec++;
    if (got_pc !== 32'h100 || got_instr !== mem_word(32'h100)) begin
      n_err++;
      $display("FAIL inflight_first got=%h/%h exp=%h/%h", got_pc, got_instr, 32'h100,
               mem_word(32'h100));
    end
  endtask

  task automatic test_redirect_coincident();
    bit          found, seen_req, seen_pop;
    logic [31:0] first_addr, first_pc, first_instr;
    lat_min = 1; lat_max = 1; imem_req_ready = 1'b1; id_ready = 1'b1;
    do_reset(2);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (mem_q.size() > 0 && mem_q[0].due <= cyc && exp_q.size() > 0 && m_discard == 0)
        found = 1;
      else begin
        settle();
        n_vec++;
        if (obs_vec !== exp_vec) begin
          n_err++;
          $display("FAIL coinc_pre cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
        end
        advance();
      end
    end
    n_vec++;
    if (!found) begin
      n_err++;
      $display("FAIL coinc_timeout got=no_response exp=response_with_data_buffered");
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0203;
    settle();
    n_vec++;
    if (obs_vec !== exp_vec) begin
      n_err++;
      $display("FAIL coinc_cycle cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
    end
    n_vec++;
    if (imem_req_valid !== 1'b0 || id_valid !== 1'b0) begin
      n_err++;
      $display("FAIL coinc_quiet got=req%b/id%b exp=req0/id0", imem_req_valid, id_valid);
    end
    advance();
    redirect_valid = 1'b0;
    seen_req = 0; seen_pop = 0;
    first_addr = 32'hDEAD_BEEF; first_pc = 32'hDEAD_BEEF; first_instr = 32'hDEAD_BEEF;
    for (int i = 0; i < 12; i++) begin
      settle();
      n_vec++;
      if (obs_vec !== exp_vec) begin
        n_err++;
        $display("FAIL coinc_post cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
      end
      if (!seen_req && imem_req_valid && imem_req_ready) begin
        seen_req = 1;
        first_addr = imem_req_addr;
      end
      if (!seen_pop && id_valid && id_ready) begin
        seen_pop = 1;
        first_pc = id_pc;
        first_instr = id_instr;
      end
      advance();
    end
    n_vec++;
    if (first_addr !== 32'h200) begin
      n_err++;
      $display("FAIL coinc_addr got=%h exp=%h", first_addr, 32'h200);
    end
    n_vec++;
    if (first_pc !== 32'h200 || first_instr !== mem_word(32'h200)) begin
      n_err++;
      $display("FAIL coinc_first got=%h/%h exp=%h/%h", first_pc, first_instr, 32'h200,
               mem_word(32'h200));
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] last_pc, first_pc;
    bit          seen;
    lat_min = 1; lat_max = 4; id_ready = 1'b1;
    do_reset(2);
    last_pc = 32'h0;
    seen = 0;
    first_pc = 32'hDEAD_BEEF;
    for (int i = 0; i < 40; i++) begin
      imem_req_ready = ($urandom_range(0, 99) < 80);
      redirect_valid = (i >= 6 && i < 9);
      redirect_pc    = $urandom;
      if (redirect_valid) last_pc = redirect_pc & ~32'h3;
      settle();
      n_vec++;
      if (obs_vec !== exp_vec) begin
        n_err++;
        $display("FAIL b2b cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
      end
      if (i >= 9 && !seen && id_valid && id_ready) begin
        seen = 1;
        first_pc = id_pc;
      end
      advance();
    end
    redirect_valid = 1'b0;
    n_vec++;
    if (first_pc !== last_pc) begin
      n_err++;
      $display("FAIL b2b_last_wins got=%h exp=%h", first_pc, last_pc);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] addrs[$];
    logic [31:0] pcs[$];
    logic [31:0] exp_a[3];
    logic [31:0] got;
    exp_a[0] = 32'hFFFF_FFF8; exp_a[1] = 32'hFFFF_FFFC; exp_a[2] = 32'h0000_0000;
    lat_min = 1; lat_max = 2; imem_req_ready = 1'b1; id_ready = 1'b1;
    do_reset(2);
    for (int i = 0; i < 20; i++) begin
      redirect_valid = (i == 0);
      redirect_pc    = 32'hFFFF_FFF9;
      settle();
      n_vec++;
      if (obs_vec !== exp_vec) begin
        n_err++;
        $display("FAIL wrap cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
      end
      if (i > 0 && imem_req_valid && imem_req_ready) addrs.push_back(imem_req_addr);
      if (i > 0 && id_valid && id_ready) pcs.push_back(id_pc);
      advance();
    end
    redirect_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      got = (addrs.size() > k) ? addrs[k] : 32'hDEAD_BEEF;
      n_vec++;
      if (got !== exp_a[k]) begin
        n_err++;
        $display("FAIL wrap_addr[%0d] got=%h exp=%h", k, got, exp_a[k]);
      end
      got = (pcs.size() > k) ? pcs[k] : 32'hDEAD_BEEF;
      n_vec++;
      if (got !== exp_a[k]) begin
        n_err++;
        $display("FAIL wrap_id_pc[%0d] got=%h exp=%h", k, got, exp_a[k]);
      end
    end
  endtask

  task automatic test_protocol_error();
    bit found;
    lat_min = 1; lat_max = 1; imem_req_ready = 1'b1; id_ready = 1'b0;
    do_reset(2);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_out == 0 && exp_q.size() == DEPTH && mem_q.size() == 0) found = 1;
      else begin
        settle();
        n_vec++;
        if (obs_vec !== exp_vec) begin
          n_err++;
          $display("FAIL proto_pre cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
        end
        advance();
      end
    end
    n_vec++;
    if (!found) begin
      n_err++;
      $display("FAIL proto_timeout got=%0d buffered exp=%0d", exp_q.size(), DEPTH);
    end
    for (int i = 0; i < 12; i++) begin
      stray_rsp = (i == 0 || i == 1);
      id_ready  = (i >= 2);
      settle();
      n_vec++;
      if (obs_vec !== exp_vec) begin
        n_err++;
        $display("FAIL proto_stray cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
      end
      advance();
    end
  endtask

  task automatic test_random();
    lat_min = 1; lat_max = 5;
    for (int i = 0; i < 2500; i++) begin
      imem_req_ready = ($urandom_range(0, 99) < 75);
      id_ready       = ($urandom_range(0, 99) < 70);
      rst            = (i == 1200) || ($urandom_range(0, 999) < 2);
      redirect_valid = !rst && ($urandom_range(0, 99) < 4);
      redirect_pc    = $urandom;
      settle();
      n_vec++;
      if (obs_vec !== exp_vec) begin
        n_err++;
        $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
      end
      advance();
    end
    rst = 1'b0;
    redirect_valid = 1'b0;
  endtask

`ifdef IFETCH_PERF_CNT_EN
  task automatic test_perf();
    bit done;
    lat_min = 1; lat_max = 1; imem_req_ready = 1'b1;
    do_reset(2);
    done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      if (m_fetched == 32'd5) done = 1;
      else begin
        id_ready = (m_stall >= 32'd3);
        settle();
        n_vec++;
        if (obs_vec !== exp_vec) begin
          n_err++;
          $display("FAIL perf_run cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
        end
        advance();
      end
    end
    id_ready = 1'b0;
    settle();
    n_vec++;
    if (perf_fetched !== 32'd5 || perf_stall !== 32'd3) begin
      n_err++;
      $display("FAIL perf_counts got=%0d/%0d exp=5/3", perf_fetched, perf_stall);
    end
    advance();
    rst = 1'b1;
    settle();
    advance();
    rst = 1'b0;
    settle();
    n_vec++;
    if (perf_fetched !== 32'd0 || perf_stall !== 32'd0) begin
      n_err++;
      $display("FAIL perf_reset got=%0d/%0d exp=0/0", perf_fetched, perf_stall);
    end
    advance();
  endtask
`endif

  initial begin
    n_vec = 0; n_err = 0; cyc = 0;
    rst = 1'b1; imem_req_ready = 1'b1; id_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    stray_rsp = 1'b0; last_due = 0; lat_min = 1; lat_max = 1;
    m_fetch_pc = 32'h0; m_rsp_pc = 32'h0; m_out = 0; m_discard = 0;
    m_fetched = 32'h0; m_stall = 32'h0;
    @(posedge clk);
    #1;
    test_reset();
    test_decode_stall();
    test_redirect_inflight();
    test_redirect_coincident();
    test_back_to_back();
    test_wrap();
    test_protocol_error();
    test_random();
`ifdef IFETCH_PERF_CNT_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
